// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 5-stage RV64 pipeline.
// Owns the PC, addresses the combinational instruction memory, and fills the
// IF/ID register. It handles stalls, flushes, redirects and out-of-range fetches.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 88,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [63:0]      redirect_target,
  output logic [63:0]      Inst_Address,
  input  logic [31:0]      Instruction,
  output logic [63:0]      ifid_pc,
  output logic [31:0]      ifid_instr,
  output logic             ifid_valid,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] fetch_count
);

  // Last byte address at which a full 32-bit word still fits in memory.
  // The compare is against this bound rather than pc+4, so a PC near the top
  // of the 64-bit space cannot wrap around and look legal.
  localparam logic [63:0]      LAST_PC = 64'(IMEM_BYTES) - 64'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [63:0]      r_pc_p0;
  logic [63:0]      r_ifid_pc_p1;
  logic [31:0]      r_ifid_instr_p1;
  logic             r_vld_p1;
  logic             r_fault;
  logic [CNT_W-1:0] r_count;

  logic [63:0]      w_pc_nxt;
  logic [63:0]      w_ifid_pc_nxt;
  logic [31:0]      w_ifid_instr_nxt;
  logic             w_vld_nxt;
  logic             w_fault_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_legal;

  assign w_legal = (r_pc_p0[1:0] == 2'b00) && (r_pc_p0 <= LAST_PC);

  // Next-state selection; earlier branches take priority over later ones.
  always_comb begin
    w_pc_nxt         = r_pc_p0;
    w_ifid_pc_nxt    = r_ifid_pc_p1;
    w_ifid_instr_nxt = r_ifid_instr_p1;
    w_vld_nxt        = r_vld_p1;
    w_fault_nxt      = r_fault;
    w_count_nxt      = r_count;
    if (redirect_valid) begin
      // The instruction fetched this cycle is on the wrong path, so it is
      // discarded even when the hazard unit is asking for a stall.
      w_pc_nxt         = redirect_target;
      w_ifid_instr_nxt = NOP_INSTR;
      w_vld_nxt        = 1'b0;
      w_fault_nxt      = 1'b0;
    end else if (stall && flush) begin
      w_ifid_instr_nxt = NOP_INSTR;
      w_vld_nxt        = 1'b0;
    end else if (stall) begin
      // Hold everything.
    end else if (flush) begin
      w_ifid_instr_nxt = NOP_INSTR;
      w_vld_nxt        = 1'b0;
    end else if (!w_legal) begin
      // PC stays put, so the unit keeps faulting until a redirect or reset.
      w_fault_nxt      = 1'b1;
      w_ifid_instr_nxt = NOP_INSTR;
      w_vld_nxt        = 1'b0;
    end else begin
      w_ifid_pc_nxt    = r_pc_p0;
      w_ifid_instr_nxt = Instruction;
      w_vld_nxt        = 1'b1;
      w_pc_nxt         = r_pc_p0 + 64'd4;
      if (r_count != CNT_MAX) w_count_nxt = r_count + 1'b1;
    end
  end

  // PC (p0) -> IF/ID register (p1)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_p0         <= RESET_PC;
      r_ifid_pc_p1    <= 64'd0;
      r_ifid_instr_p1 <= NOP_INSTR;
      r_vld_p1        <= 1'b0;
      r_fault         <= 1'b0;
      r_count         <= '0;
    end else begin
      r_pc_p0         <= w_pc_nxt;
      r_ifid_pc_p1    <= w_ifid_pc_nxt;
      r_ifid_instr_p1 <= w_ifid_instr_nxt;
      r_vld_p1        <= w_vld_nxt;
      r_fault         <= w_fault_nxt;
      r_count         <= w_count_nxt;
    end
  end

  assign Inst_Address = r_pc_p0;
  assign ifid_pc      = r_ifid_pc_p1;
  assign ifid_instr   = r_ifid_instr_p1;
  assign ifid_valid   = r_vld_p1;
  assign fetch_fault  = r_fault;
  assign fetch_count  = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a behavioural model plus an instruction-memory
// image feed a scoreboard queue. An independent monitor compares every cycle.
module tb_fetch_unit;

  localparam int CW = 4;  // narrow counter so saturation is reachable

  logic          clk = 1'b0;
  logic          reset, stall, flush, redirect_valid;
  logic [63:0]   redirect_target;
  logic [63:0]   Inst_Address;
  logic [31:0]   Instruction;
  logic [63:0]   ifid_pc;
  logic [31:0]   ifid_instr;
  logic          ifid_valid, fetch_fault;
  logic [CW-1:0] fetch_count;

  fetch_unit #(
    .RESET_PC  (64'h0),
    .IMEM_BYTES(88),
    .NOP_INSTR (32'h00000013),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .Inst_Address   (Inst_Address),
    .Instruction    (Instruction),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_valid     (ifid_valid),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // 22-word instruction memory image (88 bytes).
  logic [31:0] imem [0:21];
  initial begin
    imem[0]  = 32'h00000913; imem[1]  = 32'h00000433; imem[2]  = 32'h04b40863;
    imem[3]  = 32'h00100293; imem[4]  = 32'h00528333; imem[5]  = 32'h40628433;
    imem[6]  = 32'h0062a023; imem[7]  = 32'h0002b383; imem[8]  = 32'hfe731ce3;
    imem[9]  = 32'h00c000ef; imem[10] = 32'h00a50533; imem[11] = 32'h00093d03;
    imem[12] = 32'h01b93423; imem[13] = 32'h00890913; imem[14] = 32'hff2416e3;
    imem[15] = 32'h00008067; imem[16] = 32'h02a00513; imem[17] = 32'h00b50633;
    imem[18] = 32'h00c12023; imem[19] = 32'h00012683; imem[20] = 32'h00d60733;
    imem[21] = 32'h0000006f;
  end

  // Combinational memory: reads past the populated region return zero.
  assign Instruction = (Inst_Address < 64'd88) ? imem[Inst_Address[6:2]] : 32'h0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] ipc;
    logic [31:0] ins;
    logic        v;
    logic        f;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_ins;
  logic        m_v, m_f;
  int          m_cnt;
  localparam int CNT_MAX = (1 << CW) - 1;

  task automatic model(input logic rs, st, fl, rv, input logic [63:0] rt);
    bit legal;
    legal = (m_pc % 64'd4 == 64'd0) && (m_pc <= 64'd84);
    if (rs) begin
      m_pc = 64'd0; m_ipc = 64'd0; m_ins = 32'h13; m_v = 0; m_f = 0; m_cnt = 0;
    end else if (rv) begin
      m_pc = rt; m_ins = 32'h13; m_v = 0; m_f = 0;
    end else if (st && !fl) begin
      // everything holds
    end else if (fl) begin
      m_ins = 32'h13; m_v = 0;
    end else if (!legal) begin
      m_f = 1; m_ins = 32'h13; m_v = 0;
    end else begin
      m_ipc = m_pc; m_ins = imem[m_pc / 4]; m_v = 1; m_pc = m_pc + 4;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
  endtask

  task automatic step(input logic rs, st, fl, rv, input logic [63:0] rt);
    exp_t e;
    @(negedge clk);
    reset = rs; stall = st; flush = fl; redirect_valid = rv; redirect_target = rt;
    model(rs, st, fl, rv, rt);
    e.pc = m_pc; e.ipc = m_ipc; e.ins = m_ins; e.v = m_v; e.f = m_f;
    e.cnt = CW'(m_cnt);
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 64'd0);
  endtask

  // Monitor: one expected entry per clock edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (Inst_Address !== e.pc) begin
          errors++; $display("FAIL pc @%0t: got %h want %h", $time, Inst_Address, e.pc);
        end
        checks++;
        if (ifid_pc !== e.ipc) begin
          errors++; $display("FAIL ifid_pc @%0t: got %h want %h", $time, ifid_pc, e.ipc);
        end
        checks++;
        if (ifid_instr !== e.ins) begin
          errors++; $display("FAIL ifid_instr @%0t: got %h want %h", $time, ifid_instr, e.ins);
        end
        checks++;
        if (ifid_valid !== e.v) begin
          errors++; $display("FAIL ifid_valid @%0t: got %b want %b", $time, ifid_valid, e.v);
        end
        checks++;
        if (fetch_fault !== e.f) begin
          errors++; $display("FAIL fetch_fault @%0t: got %b want %b", $time, fetch_fault, e.f);
        end
        checks++;
        if (fetch_count !== e.cnt) begin
          errors++; $display("FAIL fetch_count @%0t: got %0d want %0d", $time, fetch_count, e.cnt);
        end
      end
    end
  end

  initial begin
    logic rs, st, fl, rv;
    logic [63:0] rt;
    int tsel;
    reset = 1; stall = 0; flush = 0; redirect_valid = 0; redirect_target = 64'd0;
    m_pc = 0; m_ipc = 0; m_ins = 32'h13; m_v = 0; m_f = 0; m_cnt = 0;

    // Reset for two cycles
    step(1, 0, 0, 0, 64'd0);
    step(1, 0, 0, 0, 64'd0);
    // Free run from 0, then stall at pc=8 for two cycles and release
    run(2);
    step(0, 1, 0, 0, 64'd0);
    step(0, 1, 0, 0, 64'd0);
    run(2);
    // Flush alone, and stall together with flush
    step(0, 0, 1, 0, 64'd0);
    step(0, 1, 1, 0, 64'd0);
    run(1);
    // Redirect overrides a stall and a flush
    step(0, 1, 1, 1, 64'h2C);
    run(1);
    // Run off the end of memory; the fault holds pc at 0x58
    run(20);
    step(0, 1, 0, 0, 64'd0);
    step(0, 0, 1, 0, 64'd0);
    run(3);
    // Redirect to 0 clears the fault
    step(0, 0, 0, 1, 64'h0);
    run(2);
    // Misaligned redirect target, then reset mid-fault while stalled
    step(0, 0, 0, 1, 64'h6);
    run(2);
    step(1, 1, 0, 0, 64'd0);
    run(1);
    // Last legal word, and a huge target that must not wrap to legal
    step(0, 0, 0, 1, 64'h54);
    run(3);
    step(0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    run(2);
    step(0, 0, 0, 1, 64'h0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rs   = ($urandom_range(0, 99) < 2);
      st   = ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 7) == 0);
      rv   = ($urandom_range(0, 11) == 0);
      tsel = $urandom_range(0, 9);
      if (tsel == 0)      rt = 64'($urandom_range(0, 100));
      else if (tsel == 1) rt = 64'hFFFF_FFFF_FFFF_FFFC;
      else                rt = 64'($urandom_range(0, 23) * 4);
      step(rs, st, fl, rv, rt);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
